dual_dac_spi: RTL and testbench

DUAL_DAC_SPI -- requirements
Module: dual_dac_spi

---
 rtl/dandy_dac_pkg.sv | 30 +++
 rtl/spi_frame_shifter.sv | 73 +++++++
 rtl/dual_dac_spi.sv | 125 ++++++++++++
 tb/tb_dual_dac_spi.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dandy_dac_pkg.sv
// Shared definitions for the dual-channel SPI DAC driver: sequencer states,
// frame header constants and the channel select codes.
package dandy_dac_pkg;

  // Transfer sequence: X frame, CS gap, Y frame, CS gap, LDAC strobe.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME_X,
    ST_GAP_X,
    ST_FRAME_Y,
    ST_GAP_Y,
    ST_LATCH
  } state_t;

  // Frame bits [14:12]: unbuffered reference, 1x gain, output active.
  localparam logic [2:0] HDR_BITS = 3'b011;

  // Frame bit [15]: DAC channel A carries X, channel B carries Y.
  localparam logic CH_X = 1'b0;
  localparam logic CH_Y = 1'b1;

  localparam int FRAME_BITS = 16;

  // Build one 16-bit DAC command word; the 8-bit sample fills the top of
  // the 12-bit data field and the low nibble is left at zero.
  function automatic logic [15:0] build_word(input logic ch, input logic [7:0] sample);
    return {ch, HDR_BITS, sample, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one 16-bit word MSB first in SPI mode 0. A start pulse loads
// the word and drops chip select on the following cycle; done is high in
// the final cycle of the frame so a sequencer can move on without a bubble.
module spi_frame_shifter
  import dandy_dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        cs_n,
  output logic        sck,
  output logic        sdi
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        active;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;

  // Last cycle of the high half of bit 0.
  assign done = active && sck && (div_cnt == DIV_LAST) && (bit_cnt == 4'd0);

  // Half-period timer and shift register; sdi only moves on the edge that
  // drops sck, so data is always stable across the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values; blocking assignments would make the result depend on
    // statement order and break the bit timing.
    if (reset) begin
      active  <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      sdi     <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      cs_n    <= 1'b0;
      sck     <= 1'b0;
      sdi     <= word[15];
      shreg   <= {word[14:0], 1'b0};
      bit_cnt <= 4'(FRAME_BITS - 1);
      div_cnt <= '0;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
        end else if (bit_cnt == 4'd0) begin
          active <= 1'b0;
          cs_n   <= 1'b1;
          sck    <= 1'b0;
          sdi    <= 1'b0;
        end else begin
          sck     <= 1'b0;
          sdi     <= shreg[15];
          shreg   <= {shreg[14:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/dual_dac_spi.sv
// Drives a dual 12-bit SPI DAC from the X/Y scan-wave generator: one sample
// pair is accepted, sent as two frames through a shared shifter, and then
// both DAC outputs are latched together with an LDAC strobe.
module dual_dac_spi
  import dandy_dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] xdac,
  input  logic [7:0] ydac,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ldac_n,
  output logic       update_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  y_reg;
  logic [7:0]  wait_cnt;
  logic        accept;
  logic        wait_last;
  logic        shift_start;
  logic        shift_done;
  logic [15:0] shift_word;

  // Ready is forced low during reset so the first post-reset cycle is the
  // first cycle that can accept a sample.
  assign sample_ready = (state == ST_IDLE) && !reset;
  assign accept       = sample_valid && sample_ready;
  assign wait_last    = (wait_cnt == DIV_LAST);

  // Pick the word and start pulse for the shifter. The X sample is captured
  // straight into the shifter on acceptance; Y is held in y_reg until its frame.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    shift_start = 1'b0;
    shift_word  = build_word(CH_X, xdac);
    case (state)
      ST_IDLE: shift_start = accept;
      ST_GAP_X: begin
        shift_start = wait_last;
        shift_word  = build_word(CH_Y, y_reg);
      end
      default: ;
    endcase
  end

  spi_frame_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .start (shift_start),
    .word  (shift_word),
    .done  (shift_done),
    .cs_n  (dac_cs_n),
    .sck   (dac_sck),
    .sdi   (dac_sdi)
  );

  // Transfer sequencer with registered LDAC strobe and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      y_reg       <= '0;
      wait_cnt    <= '0;
      dac_ldac_n  <= 1'b1;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            y_reg <= ydac;
            state <= ST_FRAME_X;
          end
        end
        ST_FRAME_X: begin
          if (shift_done) begin
            wait_cnt <= '0;
            state    <= ST_GAP_X;
          end
        end
        ST_GAP_X: begin
          if (wait_last) state <= ST_FRAME_Y;
          else           wait_cnt <= wait_cnt + 8'd1;
        end
        ST_FRAME_Y: begin
          if (shift_done) begin
            wait_cnt <= '0;
            state    <= ST_GAP_Y;
          end
        end
        ST_GAP_Y: begin
          if (wait_last) begin
            wait_cnt   <= '0;
            dac_ldac_n <= 1'b0;
            state      <= ST_LATCH;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_LATCH: begin
          if (wait_last) begin
            dac_ldac_n  <= 1'b1;
            update_done <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_dac_spi.sv
// Bench for dual_dac_spi: one instance at CLK_DIV=2 and one at CLK_DIV=1.
// A transaction-level model predicts acceptance, frame words and the
// update_done cycle; a line monitor decodes frames and checks SPI timing.
module tb_dual_dac_spi;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [2];
  logic [7:0] xdac   [2];
  logic [7:0] ydac   [2];
  logic       valid  [2];
  logic       ready  [2];
  logic       cs_n   [2];
  logic       sck    [2];
  logic       sdi    [2];
  logic       ldac_n [2];
  logic       done   [2];

  dual_dac_spi #(.CLK_DIV(DIV0)) dut0 (
    .clk(clk), .reset(rst[0]), .xdac(xdac[0]), .ydac(ydac[0]),
    .sample_valid(valid[0]), .sample_ready(ready[0]), .dac_cs_n(cs_n[0]),
    .dac_sck(sck[0]), .dac_sdi(sdi[0]), .dac_ldac_n(ldac_n[0]), .update_done(done[0])
  );

  dual_dac_spi #(.CLK_DIV(DIV1)) dut1 (
    .clk(clk), .reset(rst[1]), .xdac(xdac[1]), .ydac(ydac[1]),
    .sample_valid(valid[1]), .sample_ready(ready[1]), .dac_cs_n(cs_n[1]),
    .dac_sck(sck[1]), .dac_sdi(sdi[1]), .dac_ldac_n(ldac_n[1]), .update_done(done[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, want 0x%0h", name, i, cyc, act, exp);
    end
  endtask

  // ---------------- reference model and line monitor ----------------
  bit          mon_en   [2];
  int          ready_at [2];
  int          done_at  [2];
  logic [15:0] exp_buf  [2][16];
  int          exp_wr   [2];
  int          exp_rd   [2];
  logic [15:0] acc_w    [2];
  int          nbits    [2];
  int          frames   [2];
  logic [15:0] wx       [2];
  logic [15:0] wy       [2];
  int          hr [2], lr [2], gr [2], ldr [2];
  int          quiet    [2];
  logic        p_sck [2], p_sdi [2], p_cs [2], p_ldac [2];

  int d;
  bit m_ready;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mon_en[i]) begin
        d       = div_of(i);
        m_ready = !rst[i] && (cyc >= ready_at[i]);
        check("sample_ready", i, ready[i], m_ready);
        check("update_done", i, done[i], cyc == done_at[i]);
        if (!ldac_n[i]) check("ldac_only_while_cs_high", i, cs_n[i], 1'b1);
        if (sck[i])     check("sdi_stable_while_sck_high", i, sdi[i], p_sdi[i]);

        if (quiet[i] == 0) begin
          if (sck[i] && !p_sck[i]) begin
            check("sck_low_time", i, lr[i], d);
            acc_w[i] = {acc_w[i][14:0], sdi[i]};
            nbits[i]++;
          end
          if (!sck[i] && p_sck[i]) check("sck_high_time", i, hr[i], d);
          if (cs_n[i] && !p_cs[i] && nbits[i] != 0) begin
            check("frame_bits", i, nbits[i], 16);
            check("sck_low_after_frame", i, sck[i], 1'b0);
            if (exp_rd[i] != exp_wr[i]) begin
              check("frame_word", i, acc_w[i], exp_buf[i][exp_rd[i] % 16]);
              exp_rd[i]++;
            end else begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame dut%0d cycle %0d: got 0x%0h, want no frame", i, cyc, acc_w[i]);
            end
            if (frames[i] % 2 == 0) wx[i] = acc_w[i];
            else                    wy[i] = acc_w[i];
            frames[i]++;
            nbits[i] = 0;
          end
          if (!cs_n[i] && p_cs[i] && frames[i] % 2 == 1) check("cs_gap_time", i, gr[i], d);
          if (ldac_n[i] && !p_ldac[i]) check("ldac_low_time", i, ldr[i], d);
        end else begin
          quiet[i]--;
        end

        // Run lengths of the current level on each line.
        hr[i]  = sck[i] ? (p_sck[i] ? hr[i] + 1 : 1) : 0;
        lr[i]  = (!cs_n[i] && !sck[i]) ? ((p_sck[i] || p_cs[i]) ? 1 : lr[i] + 1) : 0;
        gr[i]  = cs_n[i] ? (p_cs[i] ? gr[i] + 1 : 1) : 0;
        ldr[i] = !ldac_n[i] ? (p_ldac[i] ? 1 : ldr[i] + 1) : 0;

        if (rst[i]) begin
          // Reset aborts whatever is in flight: nothing more is owed.
          exp_rd[i]   = exp_wr[i];
          ready_at[i] = 0;
          done_at[i]  = -1;
          nbits[i]    = 0;
          frames[i]   = 0;
          quiet[i]    = 1;
        end else if (m_ready && valid[i]) begin
          exp_buf[i][exp_wr[i] % 16] = 16'h3000 + 16'(xdac[i]) * 16'd16;
          exp_wr[i]++;
          exp_buf[i][exp_wr[i] % 16] = 16'hB000 + 16'(ydac[i]) * 16'd16;
          exp_wr[i]++;
          ready_at[i] = cyc + 1 + 67 * d;
          done_at[i]  = cyc + 1 + 67 * d;
        end

        p_sck[i]  = sck[i];
        p_sdi[i]  = sdi[i];
        p_cs[i]   = cs_n[i];
        p_ldac[i] = ldac_n[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int i, input int budget, output int when);
    when = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done[i] === 1'b1) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_update_done dut%0d: got no pulse, want one within %0d cycles", i, budget);
    end
  endtask

  task automatic send_pulse(input int i, input logic [7:0] x, input logic [7:0] y, output int acc);
    tick();
    xdac[i]  = x;
    ydac[i]  = y;
    valid[i] = 1'b1;
    acc      = cyc;
    tick();
    valid[i] = 1'b0;
  endtask

  typedef struct {
    int          inst;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] wx;
    logic [15:0] wy;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, when, seen, nd;
    logic [7:0] c;

    // Latency is counted from the clock edge that accepts the sample.
    vecs[0] = '{0, 8'h00, 8'h80, 16'h3000, 16'hB800, 134};
    vecs[1] = '{0, 8'hA5, 8'h5A, 16'h3A50, 16'hB5A0, 134};
    vecs[2] = '{0, 8'hFF, 8'h00, 16'h3FF0, 16'hB000, 134};
    vecs[3] = '{0, 8'h01, 8'hFE, 16'h3010, 16'hBFE0, 134};
    vecs[4] = '{1, 8'hFF, 8'hFF, 16'h3FF0, 16'hBFF0, 67};
    vecs[5] = '{1, 8'h00, 8'h00, 16'h3000, 16'hB000, 67};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; valid[i] = 1'b0; xdac[i] = '0; ydac[i] = '0;
      mon_en[i] = 1'b0; ready_at[i] = 0; done_at[i] = -1;
      exp_wr[i] = 0; exp_rd[i] = 0; acc_w[i] = '0; nbits[i] = 0; frames[i] = 0;
      wx[i] = 'x; wy[i] = 'x; hr[i] = 0; lr[i] = 0; gr[i] = 0; ldr[i] = 0; quiet[i] = 1;
      p_sck[i] = 1'b0; p_sdi[i] = 1'b0; p_cs[i] = 1'b1; p_ldac[i] = 1'b1;
    end

    // Reset state.
    tick(); tick(); tick();
    mon_en[0] = 1'b1;
    mon_en[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_cs_n", i, cs_n[i], 1'b1);
      check("reset_sck", i, sck[i], 1'b0);
      check("reset_sdi", i, sdi[i], 1'b0);
      check("reset_ldac_n", i, ldac_n[i], 1'b1);
      check("reset_update_done", i, done[i], 1'b0);
      check("reset_ready", i, ready[i], 1'b0);
    end
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 0, ready[0], 1'b1);
    check("ready_after_reset", 1, ready[1], 1'b1);

    // Directed vectors.
    for (int v = 0; v < 6; v++) begin
      send_pulse(vecs[v].inst, vecs[v].x, vecs[v].y, acc);
      wait_done(vecs[v].inst, 67 * div_of(vecs[v].inst) + 20, when);
      check("busy_span", vecs[v].inst, when - (acc + 1), vecs[v].lat);
      check("vec_word_x", vecs[v].inst, wx[vecs[v].inst], vecs[v].wx);
      check("vec_word_y", vecs[v].inst, wy[vecs[v].inst], vecs[v].wy);
    end

    // Valid held high with a counting input: one acceptance per update_done.
    seen = 0;
    c    = 8'h10;
    tick();
    valid[0] = 1'b1;
    for (int k = 0; k < 3 * (67 * DIV0 + 10) && seen < 3; k++) begin
      xdac[0] = c;
      ydac[0] = 8'hFF - c;
      c++;
      @(negedge clk);
      if (done[0] === 1'b1) seen++;
      tick();
    end
    check("stream_update_count", 0, seen, 3);
    valid[0] = 1'b0;
    wait_done(0, 67 * DIV0 + 20, when);

    // Randomised transactions on both instances.
    for (int t = 0; t < 16; t++) begin
      int i, hold;
      i    = int'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 4));
      repeat ($urandom_range(0, 3)) tick();
      tick();
      xdac[i]  = 8'($urandom);
      ydac[i]  = 8'($urandom);
      valid[i] = 1'b1;
      acc      = cyc;
      for (int h = 1; h < hold; h++) begin
        tick();
        xdac[i] = 8'($urandom);
        ydac[i] = 8'($urandom);
      end
      tick();
      valid[i] = 1'b0;
      wait_done(i, 67 * div_of(i) + 20, when);
      check("rand_busy_span", i, when - (acc + 1), 67 * div_of(i));
    end

    // Reset during bit 7 of the Y frame.
    send_pulse(0, 8'h3C, 8'hC3, acc);
    while (cyc < acc + 1 + 49 * DIV0 + 1) tick();
    rst[0] = 1'b1;
    @(negedge clk);
    check("cs_low_before_abort", 0, cs_n[0], 1'b0);
    tick();
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_cs_n", 0, cs_n[0], 1'b1);
    check("abort_sck", 0, sck[0], 1'b0);
    check("abort_ldac_n", 0, ldac_n[0], 1'b1);
    check("abort_ready", 0, ready[0], 1'b1);
    nd = 0;
    repeat (67 * DIV0 + 20) begin
      @(negedge clk);
      if (done[0] !== 1'b0) nd++;
    end
    check("no_update_done_after_abort", 0, nd, 0);

    // Normal operation resumes after the abort.
    send_pulse(0, 8'h12, 8'h34, acc);
    wait_done(0, 67 * DIV0 + 20, when);
    check("resume_word_x", 0, wx[0], 16'h3120);
    check("resume_word_y", 0, wy[0], 16'hB340);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
